sym_source_upsampler: RTL and testbench

//  Transmit-side symbol source driven by the clk_gen enables on clk_in.

---
 rtl/sym_source_upsampler.sv | 197 +++++++++++++++++++
 tb/tb_sym_source_upsampler.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sym_source_upsampler.sv
// Transmit symbol source: PRBS / external / training / zero symbols, Gray-mapped to
// signed 4-ASK levels and upsampled x4 on the clk_gen sample enables.
module sym_source_upsampler #(
  parameter int unsigned OUT_W      = 18,
  parameter int unsigned LEVEL_A    = 32768,
  parameter logic [14:0] LFSR_SEED  = 15'h7FFF,
  parameter int unsigned ZERO_STUFF = 1
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    sam_clk_ena,
  input  logic                    sym_clk_ena,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic [1:0]              ext_sym,
  input  logic                    ext_valid,
  output logic                    ext_ready,
  output logic signed [OUT_W-1:0] samp_out,
  output logic                    samp_valid,
  output logic                    sym_strobe,
  output logic [1:0]              sym_bits,
  output logic                    underflow
);

  typedef enum logic [1:0] {
    ModePrbs  = 2'b00,
    ModeExt   = 2'b01,
    ModeTrain = 2'b10,
    ModeZero  = 2'b11
  } mode_e;

  localparam int unsigned WideW = OUT_W + 2;
  localparam logic signed [WideW-1:0] LvlA  = WideW'(LEVEL_A);
  localparam logic signed [WideW-1:0] Lvl3A = LvlA + LvlA + LvlA;

  // Clamp a wide level into the signed OUT_W output range.
  function automatic logic signed [OUT_W-1:0] sat_level(input logic signed [WideW-1:0] v);
    logic signed [WideW-1:0] max_v;
    logic signed [WideW-1:0] min_v;
    max_v = {{3{1'b0}}, {(OUT_W-1){1'b1}}};
    min_v = {{3{1'b1}}, {(OUT_W-1){1'b0}}};
    if (v > max_v) begin
      return {1'b0, {(OUT_W-1){1'b1}}};
    end else if (v < min_v) begin
      return {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      return v[OUT_W-1:0];
    end
  endfunction

  logic signed [OUT_W-1:0] lvl_pos_a;
  logic signed [OUT_W-1:0] lvl_pos_3a;

  assign lvl_pos_a  = sat_level(LvlA);
  assign lvl_pos_3a = sat_level(Lvl3A);

  // State
  logic                    sam_ena_q, sam_ena_d;
  logic                    sym_ena_q, sym_ena_d;
  logic [14:0]             lfsr_q, lfsr_d;
  logic                    toggle_q, toggle_d;
  logic [1:0]              phase_q, phase_d;
  logic signed [OUT_W-1:0] level_q, level_d;
  logic signed [OUT_W-1:0] samp_q, samp_d;
  logic                    valid_q, valid_d;
  logic                    strobe_q, strobe_d;
  logic [1:0]              bits_q, bits_d;
  logic                    underflow_q, underflow_d;

  // Combinational helpers
  logic                    sam_tick;
  logic                    sym_tick;
  logic [14:0]             lfsr_cur;
  logic                    prbs_b1;
  logic                    prbs_b0;
  logic [14:0]             lfsr_adv;
  logic [1:0]              sym_sel;
  logic                    sym_live;
  logic                    ext_take;
  logic signed [OUT_W-1:0] gray_lvl;
  logic signed [OUT_W-1:0] sym_level;

  always_comb begin
    sam_ena_d   = sam_clk_ena;
    sym_ena_d   = sym_clk_ena;
    sam_tick    = sam_clk_ena & ~sam_ena_q;
    sym_tick    = sym_clk_ena & ~sym_ena_q;

    // Two Fibonacci steps of x^15+x^14+1; first emitted bit becomes the symbol MSB.
    lfsr_cur    = (lfsr_q == 15'd0) ? LFSR_SEED : lfsr_q;
    prbs_b1     = lfsr_cur[14] ^ lfsr_cur[13];
    prbs_b0     = lfsr_cur[13] ^ lfsr_cur[12];
    lfsr_adv    = {lfsr_cur[12:0], prbs_b1, prbs_b0};

    lfsr_d      = lfsr_q;
    toggle_d    = toggle_q;
    underflow_d = underflow_q;
    sym_sel     = 2'b00;
    sym_live    = 1'b0;
    ext_take    = 1'b0;

    if (sym_tick && enable) begin
      unique case (mode_e'(mode))
        ModePrbs: begin
          sym_sel  = {prbs_b1, prbs_b0};
          sym_live = 1'b1;
          lfsr_d   = lfsr_adv;
        end
        ModeExt: begin
          ext_take = 1'b1;
          if (ext_valid) begin
            sym_sel  = ext_sym;
            sym_live = 1'b1;
          end else begin
            underflow_d = 1'b1;
          end
        end
        ModeTrain: begin
          sym_sel  = toggle_q ? 2'b00 : 2'b10;
          sym_live = 1'b1;
          toggle_d = ~toggle_q;
        end
        ModeZero: begin
          sym_live = 1'b0;
        end
      endcase
    end

    unique case (sym_sel)
      2'b00: gray_lvl = -lvl_pos_3a;
      2'b01: gray_lvl = -lvl_pos_a;
      2'b11: gray_lvl = lvl_pos_a;
      2'b10: gray_lvl = lvl_pos_3a;
    endcase
    sym_level = sym_live ? gray_lvl : '0;

    phase_d  = phase_q;
    level_d  = level_q;
    samp_d   = samp_q;
    bits_d   = bits_q;
    valid_d  = 1'b0;
    strobe_d = 1'b0;

    if (sam_tick) begin
      valid_d = 1'b1;
      phase_d = sym_tick ? 2'd0 : 2'(phase_q + 2'd1);
      // A counter wrap to phase 0 without a symbol tick is not a symbol slot.
      if (sym_tick && (phase_d == 2'd0)) begin
        strobe_d = 1'b1;
        samp_d   = sym_level;
        level_d  = sym_level;
        bits_d   = sym_sel;
      end else if ((ZERO_STUFF != 0) || !enable) begin
        samp_d = '0;
      end else begin
        samp_d = level_q;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sam_ena_q   <= 1'b0;
      sym_ena_q   <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      toggle_q    <= 1'b0;
      phase_q     <= 2'd0;
      level_q     <= '0;
      samp_q      <= '0;
      valid_q     <= 1'b0;
      strobe_q    <= 1'b0;
      bits_q      <= 2'b00;
      underflow_q <= 1'b0;
    end else begin
      sam_ena_q   <= sam_ena_d;
      sym_ena_q   <= sym_ena_d;
      lfsr_q      <= lfsr_d;
      toggle_q    <= toggle_d;
      phase_q     <= phase_d;
      level_q     <= level_d;
      samp_q      <= samp_d;
      valid_q     <= valid_d;
      strobe_q    <= strobe_d;
      bits_q      <= bits_d;
      underflow_q <= underflow_d;
    end
  end

  // Consumption strobe is combinational so ext_valid is judged in the same cycle.
  assign ext_ready  = ext_take & ~reset;
  assign samp_out   = samp_q;
  assign samp_valid = valid_q;
  assign sym_strobe = strobe_q;
  assign sym_bits   = bits_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_sym_source_upsampler.sv
// Bench for sym_source_upsampler: clk_gen-style enables, table vectors, directed
// corner sequences and randomized inputs checked against a bit-level reference model.
module tb_sym_source_upsampler;

  localparam int unsigned OUT_W      = 18;
  localparam int unsigned LEVEL_A    = 32768;
  localparam logic [14:0] SEED       = 15'h7FFF;
  localparam int unsigned ZERO_STUFF = 1;

  logic                    clk_in = 1'b0;
  logic                    reset;
  logic                    sam_clk_ena;
  logic                    sym_clk_ena;
  logic                    enable;
  logic [1:0]              mode;
  logic [1:0]              ext_sym;
  logic                    ext_valid;
  logic                    ext_ready;
  logic signed [OUT_W-1:0] samp_out;
  logic                    samp_valid;
  logic                    sym_strobe;
  logic [1:0]              sym_bits;
  logic                    underflow;

  always #5 clk_in = ~clk_in;

  sym_source_upsampler #(
    .OUT_W      (OUT_W),
    .LEVEL_A    (LEVEL_A),
    .LFSR_SEED  (SEED),
    .ZERO_STUFF (ZERO_STUFF)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .sam_clk_ena (sam_clk_ena),
    .sym_clk_ena (sym_clk_ena),
    .enable      (enable),
    .mode        (mode),
    .ext_sym     (ext_sym),
    .ext_valid   (ext_valid),
    .ext_ready   (ext_ready),
    .samp_out    (samp_out),
    .samp_valid  (samp_valid),
    .sym_strobe  (sym_strobe),
    .sym_bits    (sym_bits),
    .underflow   (underflow)
  );

  int n_checks = 0;
  int n_errors = 0;
  int gen_cnt  = 0;
  bit gen_auto = 1'b1;
  int rdy_cnt  = 0;

  // Reference model state: PRBS kept as a plain bit history (oldest first).
  bit         m_q[$];
  logic       m_sam_d, m_sym_d, m_toggle, m_uf;
  int         m_level;
  int         e_samp;
  logic       e_valid, e_strobe;
  logic [1:0] e_bits;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gray_level(input logic [1:0] b);
    int     idx;
    longint v;
    longint maxv;
    idx  = int'({b[1], b[1] ^ b[0]});
    v    = longint'(2 * idx - 3) * longint'(LEVEL_A);
    maxv = (longint'(1) << (OUT_W - 1)) - 1;
    if (v > maxv) v = maxv;
    if (v < -maxv) v = -maxv;
    return int'(v);
  endfunction

  task automatic model_reset();
    logic [14:0] s;
    s = SEED;
    m_q.delete();
    for (int i = 0; i < 15; i++) m_q.push_back(s[14-i]);
    m_sam_d  = 1'b0;
    m_sym_d  = 1'b0;
    m_toggle = 1'b0;
    m_uf     = 1'b0;
    m_level  = 0;
    e_samp   = 0;
    e_valid  = 1'b0;
    e_strobe = 1'b0;
    e_bits   = 2'b00;
  endtask

  task automatic prbs_sym(output logic [1:0] b);
    bit nb;
    bit any;
    logic [14:0] s;
    b = 2'b00;
    for (int k = 0; k < 2; k++) begin
      any = 1'b0;
      foreach (m_q[j]) any |= m_q[j];
      if (!any) begin
        s = SEED;
        m_q.delete();
        for (int i = 0; i < 15; i++) m_q.push_back(s[14-i]);
      end
      nb = m_q[0] ^ m_q[1];
      void'(m_q.pop_front());
      m_q.push_back(nb);
      b = {b[0], nb};
    end
  endtask

  task automatic model_clock();
    logic       st, yt;
    logic [1:0] b;
    int         lvl;
    st      = sam_clk_ena && !m_sam_d;
    yt      = sym_clk_ena && !m_sym_d;
    m_sam_d = sam_clk_ena;
    m_sym_d = sym_clk_ena;
    b       = 2'b00;
    lvl     = 0;
    if (yt && enable) begin
      case (mode)
        2'b00: begin prbs_sym(b); lvl = gray_level(b); end
        2'b01: begin
          if (ext_valid) begin b = ext_sym; lvl = gray_level(b); end
          else m_uf = 1'b1;
        end
        2'b10: begin
          b        = m_toggle ? 2'b00 : 2'b10;
          m_toggle = !m_toggle;
          lvl      = gray_level(b);
        end
        default: ;
      endcase
    end
    e_valid  = st;
    e_strobe = st && yt;
    if (st && yt) begin
      e_samp  = lvl;
      e_bits  = b;
      m_level = lvl;
    end else if (st) begin
      e_samp = (!enable || ZERO_STUFF != 0) ? 0 : m_level;
    end
  endtask

  // One clk_in cycle: called just after a falling edge with inputs already set.
  task automatic cyc();
    if (gen_auto) begin
      sam_clk_ena = (gen_cnt % 8) < 2;
      sym_clk_ena = gen_cnt < 2;
      gen_cnt     = (gen_cnt + 1) % 32;
    end
    #1;
    check("ext_ready", 32'(ext_ready),
          (!reset && enable && mode == 2'b01 && sym_clk_ena && !m_sym_d) ? 1 : 0);
    if (ext_ready === 1'b1) rdy_cnt++;
    @(posedge clk_in);
    if (reset) model_reset();
    else model_clock();
    #1;
    check("samp_out", 32'(samp_out), e_samp);
    check("samp_valid", 32'(samp_valid), 32'(e_valid));
    check("sym_strobe", 32'(sym_strobe), 32'(e_strobe));
    check("sym_bits", 32'(sym_bits), 32'(e_bits));
    check("underflow", 32'(underflow), 32'(m_uf));
    @(negedge clk_in);
  endtask

  task automatic run_to_sym();
    for (int i = 0; i < 40 && gen_cnt != 0; i++) cyc();
    if (gen_cnt != 0) begin
      n_errors++;
      $display("FAIL sym_align: counter %0d, required 0", gen_cnt);
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [1:0] ext_sym;
    logic       ext_valid;
    logic       en;
    int         exp_samp;
    logic [1:0] exp_bits;
    int         exp_rdy;
    logic       exp_uf;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int vcnt;
    int scnt;

    vecs[0]  = '{2'b10, 2'b00, 1'b1, 1'b1,  98304, 2'b10, 0, 1'b0};
    vecs[1]  = '{2'b10, 2'b00, 1'b1, 1'b1, -98304, 2'b00, 0, 1'b0};
    vecs[2]  = '{2'b10, 2'b00, 1'b1, 1'b1,  98304, 2'b10, 0, 1'b0};
    vecs[3]  = '{2'b01, 2'b01, 1'b1, 1'b1, -32768, 2'b01, 1, 1'b0};
    vecs[4]  = '{2'b01, 2'b11, 1'b1, 1'b1,  32768, 2'b11, 1, 1'b0};
    vecs[5]  = '{2'b01, 2'b00, 1'b1, 1'b1, -98304, 2'b00, 1, 1'b0};
    vecs[6]  = '{2'b01, 2'b10, 1'b1, 1'b1,  98304, 2'b10, 1, 1'b0};
    vecs[7]  = '{2'b01, 2'b01, 1'b0, 1'b1,      0, 2'b00, 1, 1'b1};
    vecs[8]  = '{2'b01, 2'b11, 1'b1, 1'b1,  32768, 2'b11, 1, 1'b1};
    vecs[9]  = '{2'b11, 2'b10, 1'b1, 1'b1,      0, 2'b00, 0, 1'b1};
    vecs[10] = '{2'b10, 2'b00, 1'b1, 1'b0,      0, 2'b00, 0, 1'b1};
    vecs[11] = '{2'b10, 2'b00, 1'b1, 1'b1, -98304, 2'b00, 0, 1'b1};
    vecs[12] = '{2'b01, 2'b11, 1'b1, 1'b0,      0, 2'b00, 0, 1'b1};

    reset       = 1'b1;
    sam_clk_ena = 1'b0;
    sym_clk_ena = 1'b0;
    enable      = 1'b1;
    mode        = 2'b00;
    ext_sym     = 2'b00;
    ext_valid   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_in);

    // Reset state, then PRBS from the seed.
    repeat (3) cyc();
    reset = 1'b0;
    run_to_sym();
    cyc();
    check("prbs_first_bits", 32'(sym_bits), 0);
    check("prbs_first_samp", 32'(samp_out), -98304);
    check("prbs_first_strobe", 32'(sym_strobe), 1);
    vcnt = 1;
    for (int i = 0; i < 31; i++) begin
      cyc();
      if (samp_valid === 1'b1) vcnt++;
    end
    check("valid_per_symbol", vcnt, 4);

    // Table vectors: one symbol period each.
    foreach (vecs[i]) begin
      mode      = vecs[i].mode;
      ext_sym   = vecs[i].ext_sym;
      ext_valid = vecs[i].ext_valid;
      enable    = vecs[i].en;
      rdy_cnt   = 0;
      cyc();
      check($sformatf("vec%0d_samp", i), 32'(samp_out), vecs[i].exp_samp);
      check($sformatf("vec%0d_bits", i), 32'(sym_bits), 32'(vecs[i].exp_bits));
      check($sformatf("vec%0d_strobe", i), 32'(sym_strobe), 1);
      repeat (31) cyc();
      check($sformatf("vec%0d_rdy_count", i), rdy_cnt, vecs[i].exp_rdy);
      check($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].exp_uf));
    end

    // PRBS pause: LFSR frozen while disabled, sample timing unbroken.
    mode      = 2'b00;
    ext_valid = 1'b1;
    enable    = 1'b1;
    repeat (4 * 32) cyc();
    enable = 1'b0;
    vcnt   = 0;
    scnt   = 0;
    for (int i = 0; i < 3 * 32; i++) begin
      cyc();
      if (samp_valid === 1'b1) vcnt++;
      if (sym_strobe === 1'b1) scnt++;
    end
    check("disabled_valid_count", vcnt, 12);
    check("disabled_strobe_count", scnt, 3);
    enable = 1'b1;
    repeat (4 * 32) cyc();

    // Randomized inputs, changed at arbitrary cycles.
    for (int s = 0; s < 48; s++) begin
      for (int c = 0; c < 32; c++) begin
        if ($urandom_range(5) == 0) begin
          mode      = 2'($urandom_range(3));
          ext_sym   = 2'($urandom_range(3));
          ext_valid = ($urandom_range(3) != 0);
          enable    = ($urandom_range(7) != 0);
        end
        cyc();
      end
    end

    // Enable held high for 5 cycles must still tick only once.
    mode        = 2'b00;
    enable      = 1'b1;
    ext_valid   = 1'b1;
    gen_auto    = 1'b0;
    sam_clk_ena = 1'b0;
    sym_clk_ena = 1'b0;
    repeat (3) cyc();
    sam_clk_ena = 1'b1;
    sym_clk_ena = 1'b1;
    vcnt        = 0;
    scnt        = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) begin
        sam_clk_ena = 1'b0;
        sym_clk_ena = 1'b0;
      end
      cyc();
      if (samp_valid === 1'b1) vcnt++;
      if (sym_strobe === 1'b1) scnt++;
    end
    check("long_enable_valid", vcnt, 1);
    check("long_enable_strobe", scnt, 1);
    gen_auto = 1'b1;
    gen_cnt  = 0;

    // Reset mid-symbol: everything back to reset values, LFSR back to the seed.
    for (int i = 0; i < 40 && gen_cnt != 13; i++) cyc();
    reset = 1'b1;
    repeat (2) cyc();
    check("midreset_samp", 32'(samp_out), 0);
    check("midreset_underflow", 32'(underflow), 0);
    check("midreset_bits", 32'(sym_bits), 0);
    reset = 1'b0;
    run_to_sym();
    cyc();
    check("post_reset_bits", 32'(sym_bits), 0);
    check("post_reset_samp", 32'(samp_out), -98304);
    repeat (40) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
